// File: rtl/cht_unshift.sv
// rtl/cht_unshift.sv - restores a shifted word by stepping it back one position per cycle
module cht_unshift #(
    parameter int W = 16,
    localparam int AW = (W > 1) ? $clog2(W) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_dir,
    input  logic [AW-1:0] in_amt,
    input  logic          in_fill,
    input  logic          hold,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q;
    logic [W-1:0]  data_q;
    logic [W-1:0]  out_q;
    logic [AW-1:0] cnt_q;
    logic          dir_q;
    logic          fill_q;
    logic [W-1:0]  stepped;

    // One step against the original shift direction, fill entering the vacated end
    always_comb begin
        stepped = data_q;
        if (dir_q)
            stepped = {fill_q, data_q[W-1:1]};
        else
            stepped = {data_q[W-2:0], fill_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        dir_q  <= in_dir;
                        fill_q <= in_fill;
                        cnt_q  <= in_amt;
                        if (in_amt == '0) begin
                            state_q <= S_DONE;
                            out_q   <= in_data;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (!hold) begin
                        data_q <= stepped;
                        // Leave on the last step so the counter never underflows
                        if (cnt_q <= AW'(1)) begin
                            cnt_q   <= '0;
                            state_q <= S_DONE;
                            out_q   <= stepped;
                        end else begin
                            cnt_q <= cnt_q - AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign out_data  = out_q;

endmodule

// File: tb/tb_cht_unshift.sv
// tb/tb_cht_unshift.sv - directed vector bench for cht_unshift
module tb_cht_unshift;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_dir;
    logic [3:0]  in_amt;
    logic        in_fill;
    logic        hold;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int failures = 0;

    cht_unshift #(.W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .in_fill   (in_fill),
        .hold      (hold),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        dir;
        logic [3:0]  amt;
        logic        fill;
        int          hs;
        int          hl;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, output logic [15:0] res, output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_data  = v.data;
        in_dir   = v.dir;
        in_amt   = v.amt;
        in_fill  = v.fill;
        tick();
        in_valid = 1'b0;
        in_data  = ~v.data;
        in_dir   = ~v.dir;
        in_amt   = 4'd9;
        in_fill  = ~v.fill;
        lat = 1;
        while (!out_valid && lat < 100) begin
            hold = (lat >= v.hs) && (lat < v.hs + v.hl);
            tick();
            lat++;
        end
        hold = 1'b0;
        res = out_data;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] res;
        int          lat;
        int          seen;

        vecs[0] = '{16'hA5C3, 1'b0, 4'd0,  1'b0, 0, 0, 16'hA5C3, 1};
        vecs[1] = '{16'h5A30, 1'b1, 4'd4,  1'b0, 0, 0, 16'h05A3, 5};
        vecs[2] = '{16'h0F0F, 1'b0, 4'd3,  1'b1, 0, 0, 16'h787F, 4};
        vecs[3] = '{16'h5A30, 1'b1, 4'd4,  1'b0, 2, 2, 16'h05A3, 7};
        vecs[4] = '{16'h8000, 1'b1, 4'd15, 1'b1, 0, 0, 16'hFFFF, 16};
        vecs[5] = '{16'h0001, 1'b0, 4'd15, 1'b0, 0, 0, 16'h8000, 16};
        vecs[6] = '{16'hFFFF, 1'b0, 4'd1,  1'b0, 0, 0, 16'hFFFE, 2};
        vecs[7] = '{16'h1234, 1'b1, 4'd8,  1'b0, 3, 1, 16'h0012, 10};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
        in_amt = '0; in_fill = 1'b0; hold = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        chk("reset_in_ready",  {63'd0, in_ready},  64'd0);
        chk("reset_busy",      {63'd0, busy},      64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_data",  {48'd0, out_data},  64'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], res, lat);
            chk($sformatf("vec%0d_data", i), {48'd0, res}, {48'd0, vecs[i].exp});
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            tick();
            chk($sformatf("vec%0d_valid_drop", i), {63'd0, out_valid}, 64'd0);
            chk($sformatf("vec%0d_idle", i), {63'd0, busy}, 64'd0);
        end

        // Backpressure in DONE with a competing word waiting upstream
        out_ready = 1'b0;
        run_vec('{16'h00F0, 1'b0, 4'd2, 1'b0, 0, 0, 16'h03C0, 3}, res, lat);
        chk("bp_data", {48'd0, res}, 64'h03C0);
        chk("bp_latency", 64'(lat), 64'd3);
        in_valid = 1'b1; in_data = 16'h1111; in_amt = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid_held",  {63'd0, out_valid}, 64'd1);
            chk("bp_data_stable", {48'd0, out_data},  64'h03C0);
            chk("bp_in_ready",    {63'd0, in_ready},  64'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_busy",  {63'd0, busy},      64'd0);
        chk("bp_release_ready", {63'd0, in_ready},  64'd1);
        tick();
        chk("bp_no_second_accept", {63'd0, busy}, 64'd0);

        // Reset asserted in the middle of a shift
        in_valid = 1'b1; in_data = 16'hBEEF; in_dir = 1'b1; in_amt = 4'd8; in_fill = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("abort_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
        chk("abort_out_data",  {48'd0, out_data},  64'd0);
        chk("abort_busy",      {63'd0, busy},      64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("abort_no_emit", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
